// File: rtl/fp_sub_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single subtractor between two requesters.
// Optional WAIT-state watchdog enabled by defining FP_SUB_ARB_TIMEOUT_EN.
module fp_sub_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] z0,
  output logic [31:0] z1,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  output logic        sub_start,
  output logic        sub_ack,
  input  logic [31:0] sub_z,
  input  logic        sub_valid,
  input  logic        sub_idle,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_e;

  state_e      state_q;
  logic        last_q;
  logic        owner_q;
  logic        busy_q;
  logic        start_q;
  logic        ack_q;
  logic        done0_q;
  logic        done1_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] z0_q;
  logic [31:0] z1_q;
  logic        gnt;

`ifdef FP_SUB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic [CW-1:0] cnt_q;
  logic          terr_q;
`endif

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign gnt = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      z0_q    <= 32'h0;
      z1_q    <= 32'h0;
`ifdef FP_SUB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if ((req0 || req1) && sub_idle) begin
            owner_q <= gnt;
            a_q     <= gnt ? a1 : a0;
            b_q     <= gnt ? b1 : b0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef FP_SUB_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sub_valid) begin
            if (owner_q) z1_q <= sub_z;
            else         z0_q <= sub_z;
            ack_q   <= 1'b1;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_DELIVER;
          end
`ifdef FP_SUB_ARB_TIMEOUT_EN
          // Watchdog: deliver a quiet NaN once the WAIT budget is spent.
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            if (owner_q) z1_q <= QNAN;
            else         z0_q <= QNAN;
            terr_q  <= 1'b1;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_DELIVER;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_DELIVER: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign z0        = z0_q;
  assign z1        = z1_q;
  assign sub_a     = a_q;
  assign sub_b     = b_q;
  assign sub_start = start_q;
  assign sub_ack   = ack_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef FP_SUB_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Scoreboard bench for fp_sub_arbiter with a behavioural subtractor and round-robin model.
module tb_fp_sub_arbiter;
  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic        done0, done1, sub_start, sub_ack, busy, owner, timeout_err;
  logic [31:0] z0, z1, sub_a, sub_b;
  logic [31:0] sub_z = '0;
  logic        sub_valid = 1'b0;
  logic        sub_idle = 1'b1;

  fp_sub_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .done0(done0), .done1(done1), .z0(z0), .z1(z1),
    .sub_a(sub_a), .sub_b(sub_b), .sub_start(sub_start), .sub_ack(sub_ack),
    .sub_z(sub_z), .sub_valid(sub_valid), .sub_idle(sub_idle),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    bit          to;
  } op_t;

  op_t         exp_q[$];
  op_t         cur;
  int          checks = 0;
  int          failures = 0;
  int          ncyc = 0;
  int          valid_cyc = 0;
  int          start_cyc = 0;
  bit          in_op = 0;
  bit          last_m = 1;
  bit          terr_m = 0;
  logic [31:0] z0_m = '0, z1_m = '0;
  bit          force_busy = 0;
  bit          no_resp = 0;
  bit          pend = 0;
  int          lat = 0;

  function automatic logic [31:0] f32(int v);
    logic        s;
    int unsigned m;
    int          e;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? int'(-v) : v;
    e = 0;
    for (int i = 0; i < 31; i++) if (m[i]) e = i;
    return {s, 8'(127 + e), 23'((m << (23 - e)) & 32'h7F_FFFF)};
  endfunction

  function automatic int int_of(logic [31:0] f);
    int e;
    int mag;
    if (f[30:23] == 8'h0) return 0;
    e   = int'(f[30:23]) - 127;
    mag = int'({9'h1, f[22:0]} >> (23 - e));
    return f[31] ? -mag : mag;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Stand-in subtractor: random latency, one-cycle valid pulse, shares rst.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      sub_valid = 1'b0;
    end else if (sub_valid) begin
      sub_valid = 1'b0;
      pend = 0;
    end else if (pend) begin
      lat--;
      if (lat == 0) begin
        sub_z = f32(int_of(sub_a) - int_of(sub_b));
        sub_valid = 1'b1;
        valid_cyc = ncyc;
      end
    end else if (sub_start && !no_resp) begin
      pend = 1;
      lat = int'($urandom_range(1, 4));
    end
    sub_idle = !force_busy && !pend;
  end

  // Monitor: pops the predicted operation on each start, checks it on each done.
  always @(negedge clk) begin
    if (rst) begin
      in_op = 0;
      z0_m = '0;
      z1_m = '0;
      terr_m = 0;
    end else begin
      chk("excl", {30'h0, done0 & done1, sub_start & sub_ack}, 32'h0);
      if (sub_start) begin
        if (exp_q.size() == 0) fail_now("unexpected_start");
        else begin
          cur = exp_q.pop_front();
          chk("grant_owner", {31'h0, owner}, {31'h0, cur.who});
          chk("issue_a", sub_a, cur.a);
          chk("issue_b", sub_b, cur.b);
          start_cyc = ncyc;
          in_op = 1;
        end
      end else if (in_op) begin
        chk("stable_a", sub_a, cur.a);
        chk("stable_b", sub_b, cur.b);
      end
      if (done0 || done1) begin
        if (!in_op) fail_now("unexpected_done");
        else begin
          chk("done_who", {31'h0, done1}, {31'h0, cur.who});
          if (cur.who) z1_m = cur.z;
          else         z0_m = cur.z;
          chk("z0", z0, z0_m);
          chk("z1", z1, z1_m);
          chk("ack_at_done", {31'h0, sub_ack}, {31'h0, !cur.to});
          if (cur.to) begin
            terr_m = 1;
            chk("timeout_lat", 32'(ncyc), 32'(start_cyc + 1 + int'(TO_CYC)));
          end else begin
            chk("done_lat", 32'(ncyc), 32'(valid_cyc + 1));
          end
          chk("timeout_err", {31'h0, timeout_err}, {31'h0, terr_m});
          in_op = 0;
        end
      end else if (sub_ack) begin
        fail_now("stray_ack");
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    chk("rst_done", {30'h0, done0, done1}, 32'h0);
    chk("rst_z0", z0, 32'h0);
    chk("rst_z1", z1, 32'h0);
    chk("rst_sub_a", sub_a, 32'h0);
    chk("rst_sub_b", sub_b, 32'h0);
    chk("rst_ctrl", {27'h0, sub_start, sub_ack, busy, owner, timeout_err}, 32'h0);
    exp_q.delete();
    last_m = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_dones(input int n);
    int got = 0;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        got++;
        if (n <= 2) begin
          if (done0) req0 = 1'b0;
          if (done1) req1 = 1'b0;
        end else if (got == n) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    checks++;
    if (got < n) begin
      failures++;
      $display("FAIL done_wait actual=%0d required=%0d", got, n);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // Predict the service order from round-robin rules, then drive the requests.
  task automatic run_round(input bit r0, input bit r1, input bit drop, input int nops,
                           input int ia0, input int ib0, input int ia1, input int ib1);
    bit first;
    op_t o;
    a0 = f32(ia0); b0 = f32(ib0); a1 = f32(ia1); b1 = f32(ib1);
    first = (r0 && r1) ? ~last_m : r1;
    for (int k = 0; k < nops; k++) begin
      o.who = first ^ k[0];
      o.a   = o.who ? a1 : a0;
      o.b   = o.who ? b1 : b0;
      o.z   = o.who ? f32(ia1 - ib1) : f32(ia0 - ib0);
      o.to  = 0;
      exp_q.push_back(o);
      last_m = o.who;
    end
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    @(negedge clk);
    chk("start_lat", {31'h0, sub_start}, 32'h1);
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    wait_dones(nops);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  initial begin
    op_t o;
    do_reset();
    run_round(1, 0, 0, 1, 3, 1, 0, 0);
    do_reset();
    run_round(1, 1, 0, 2, 3, 1, 5, 2);
    chk("z1_pair", z1, 32'h4040_0000);
    run_round(1, 1, 0, 4, rnd(), rnd(), rnd(), rnd());

    // Subtractor reports busy: no grant until it goes idle.
    force_busy = 1;
    @(negedge clk);
    a0 = f32(7); b0 = f32(-9);
    o.who = 0; o.a = a0; o.b = b0; o.z = f32(16); o.to = 0;
    exp_q.push_back(o);
    last_m = 0;
    req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_block_start", {30'h0, sub_start, busy}, 32'h0);
    end
    force_busy = 0;
    wait_dones(1);

    for (int r = 0; r < 20; r++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      run_round(sel != 1, sel != 0, (sel != 2) && ($urandom_range(0, 1) == 1),
                (sel == 2) ? 2 : 1, rnd(), rnd(), rnd(), rnd());
    end

    // Abort mid-operation: no done may follow.
    a0 = f32(4); b0 = f32(1);
    o.who = 0; o.a = a0; o.b = b0; o.z = f32(3); o.to = 0;
    exp_q.push_back(o);
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("busy_after_rst", {31'h0, busy}, 32'h0);
    repeat (10) @(negedge clk);

`ifdef FP_SUB_ARB_TIMEOUT_EN
    no_resp = 1;
    a1 = f32(2); b1 = f32(1);
    o.who = 1; o.a = a1; o.b = b1; o.z = 32'h7FC0_0000; o.to = 1;
    exp_q.push_back(o);
    last_m = 1;
    @(negedge clk);
    req1 = 1'b1;
    wait_dones(1);
    no_resp = 0;
    run_round(1, 0, 0, 1, 9, 4, 0, 0);
    chk("timeout_sticky", {31'h0, timeout_err}, 32'h1);
`endif

    do_reset();
    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
